// File: rtl/fir_output_collector_if.sv
// Sample stream into the collector and ready/valid drain port toward the host.
interface fir_output_collector_if #(
  parameter int IN_W  = 38,
  parameter int OUT_W = 16
);
  logic                    in_valid;
  logic signed [IN_W-1:0]  y_in;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_last;
  logic                    out_ready;

  modport slave  (input  in_valid, y_in, out_ready, output out_data, out_valid, out_last);
  modport master (output in_valid, y_in, out_ready, input  out_data, out_valid, out_last);
endinterface

// File: rtl/fir_output_collector.sv
// FIR sink: skips the N-1 transient outputs, rounds/saturates one frame to Q15
// and buffers it in a small FIFO drained over a ready/valid port.
module fir_output_collector #(
  parameter int N     = 37,
  parameter int IN_W  = 38,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int FRAME = 1000,
  parameter int DEPTH = 16
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  fir_output_collector_if.slave  bus,
  output logic                   busy,
  output logic                   done,
  output logic                   sat_flag,
  output logic                   overflow
);
  localparam int AW  = $clog2(DEPTH);
  localparam int SKW = $clog2(N + 1);
  localparam int FCW = $clog2(FRAME + 1);
  localparam int QW  = IN_W + 1 - SHIFT;
  localparam logic [SKW-1:0]          SKIP_LAST = SKW'((N > 1) ? N - 2 : 0);
  localparam logic [FCW-1:0]          FRM_LAST  = FCW'(FRAME - 1);
  localparam logic signed [IN_W:0]    HALF      = (IN_W + 1)'(2 ** (SHIFT - 1));
  localparam logic signed [QW-1:0]    QMAX      = QW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [QW-1:0]    QMIN      = QW'(-(2 ** (OUT_W - 1)));
  localparam logic signed [OUT_W-1:0] SMAX      = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] SMIN      = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DRAIN} state_t;
  typedef struct packed {
    logic                    last;
    logic signed [OUT_W-1:0] data;
  } entry_t;

  state_t             state, nstate;
  logic [SKW-1:0]     skip_cnt;
  logic [FCW-1:0]     frm_cnt;
  logic               arm, accept, pop, full, wr_en, drop;
  logic signed [IN_W:0]   r;
  logic signed [QW-1:0]   q;
  entry_t             s1, s1_d, head;
  logic               s1_vld, sat_d;
  entry_t             mem [DEPTH];
  logic [AW:0]        wptr, rptr, cnt;

  assign arm    = (state == IDLE) && start;
  assign accept = (state == CAPTURE) && bus.in_valid;

  // FSM: state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= nstate;

  // FSM: next state
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start) nstate = (N == 1) ? CAPTURE : SETTLE;
      SETTLE:  if (bus.in_valid && skip_cnt == SKIP_LAST) nstate = CAPTURE;
      CAPTURE: if (accept && frm_cnt == FRM_LAST) nstate = DRAIN;
      DRAIN:   if (done) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // FSM: outputs. A dropped last sample still ends the frame once the FIFO empties.
  always_comb begin
    busy = (state != IDLE);
    done = 1'b0;
    if (state == DRAIN && !s1_vld)
      done = (cnt == '0) || (cnt == (AW+1)'(1) && pop);
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      skip_cnt <= '0;
      frm_cnt  <= '0;
    end else if (arm) begin
      skip_cnt <= '0;
      frm_cnt  <= '0;
    end else begin
      if (state == SETTLE && bus.in_valid) skip_cnt <= skip_cnt + 1'b1;
      if (accept)                          frm_cnt  <= frm_cnt + 1'b1;
    end

  // Round-half-up then clamp to the signed output range
  always_comb begin
    r           = {bus.y_in[IN_W-1], bus.y_in} + HALF;
    q           = QW'(r >>> SHIFT);
    sat_d       = 1'b0;
    s1_d.data   = q[OUT_W-1:0];
    s1_d.last   = (frm_cnt == FRM_LAST);
    if (q > QMAX) begin
      s1_d.data = SMAX;
      sat_d     = 1'b1;
    end else if (q < QMIN) begin
      s1_d.data = SMIN;
      sat_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1_vld <= 1'b0;
      s1     <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) s1 <= s1_d;
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sat_flag <= 1'b0;
      overflow <= 1'b0;
    end else if (arm) begin
      sat_flag <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (accept && sat_d) sat_flag <= 1'b1;
      if (drop)            overflow <= 1'b1;
    end

  // FIFO: a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign cnt   = wptr - rptr;
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign pop   = bus.out_valid && bus.out_ready;
  assign wr_en = s1_vld && (!full || pop);
  assign drop  = s1_vld && full && !pop;

  always_ff @(posedge clk)
    if (wr_en) mem[wptr[AW-1:0]] <= s1;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
    end

  assign head          = mem[rptr[AW-1:0]];
  assign bus.out_valid = (cnt != '0);
  assign bus.out_data  = bus.out_valid ? head.data : '0;
  assign bus.out_last  = bus.out_valid && head.last;
endmodule

// File: tb/tb_fir_output_collector.sv
// Directed scenarios for fir_output_collector with a queue scoreboard on the drain port.
module tb_fir_output_collector;
  localparam int N = 37, IN_W = 38, OUT_W = 16, SHIFT = 15, FRAME = 1000, DEPTH = 16;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic busy, done, sat_flag, overflow;

  fir_output_collector_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  fir_output_collector #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT),
                         .FRAME(FRAME), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus.slave),
    .busy(busy), .done(done), .sat_flag(sat_flag), .overflow(overflow));

  always #5 clk = ~clk;

  typedef struct { logic signed [15:0] data; logic last; } exp_t;
  exp_t sbq[$];
  int npass = 0, nfail = 0, ntot = 0;
  int n_out = 0, n_done = 0, n_last = 0, idx = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [15:0] model(input logic signed [37:0] y);
    longint q;
    q = (longint'(y) + 16384) >>> 15;
    if (q > 32767)  return 16'sh7fff;
    if (q < -32768) return 16'sh8000;
    return q[15:0];
  endfunction

  function automatic logic signed [37:0] sc(input int v);
    return 38'(longint'(v) * 32768);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drain-side monitor: every handshake pops one expected entry
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (bus.out_last) n_last++;
        if (sbq.size() == 0) chk("unexpected_out", 64'sd1, 64'sd0);
        else begin
          e = sbq.pop_front();
          chk("out_data", bus.out_data, e.data);
          chk("out_last", bus.out_last, e.last);
        end
      end
      if (done) n_done++;
    end
  end

  task automatic feed_e(input logic signed [37:0] y, input logic signed [15:0] e, input bit keep);
    exp_t x;
    bus.in_valid = 1'b1;
    bus.y_in     = y;
    if (keep && idx >= N-1 && idx < N-1+FRAME) begin
      x.data = e;
      x.last = (idx == N-2+FRAME);
      sbq.push_back(x);
    end
    idx++;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic feed(input logic signed [37:0] y);
    feed_e(y, model(y), 1'b1);
  endtask

  // Start pulse with a coincident sample that must not be counted
  task automatic arm_frame;
    n_out = 0; n_done = 0; n_last = 0; idx = 0;
    start = 1'b1; bus.in_valid = 1'b1; bus.y_in = sc(999);
    tick();
    start = 1'b0; bus.in_valid = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("sat_cleared", sat_flag, 0);
    chk("ovf_cleared", overflow, 0);
  endtask

  task automatic finish_frame(input int exp_out, input int exp_last);
    int k = 0;
    while (busy && k < 200) begin
      tick();
      k++;
    end
    chk("drain_busy", busy, 0);
    chk("sb_empty", sbq.size(), 0);
    chk("n_out", n_out, exp_out);
    chk("n_last", n_last, exp_last);
    chk("n_done", n_done, 1);
  endtask

  task automatic run_ramp;
    bus.out_ready = 1'b1;
    arm_frame();
    for (int i = 0; i < N-1+FRAME; i++) begin
      if (i == 500) start = 1'b1;
      feed(sc(i));
      start = 1'b0;
      if (i == 36) chk("lat_not_yet", bus.out_valid, 0);
      if (i == 37) chk("lat_two", bus.out_valid, 1);
      if (i == 500) chk("busy_ignore_start", busy, 1);
    end
    finish_frame(FRAME, 1);
    chk("ramp_sat", sat_flag, 0);
    chk("ramp_ovf", overflow, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.y_in = '0; bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b1;
    tick();

    // Transient skip, throughput, start-while-busy
    run_ramp();

    // Rounding and saturation
    arm_frame();
    repeat (N-1) feed(38'sd0);
    feed_e(38'sd16384, 16'sd1, 1'b1);
    feed_e(38'sd16383, 16'sd0, 1'b1);
    feed_e(-38'sd16384, 16'sd0, 1'b1);
    feed_e(-38'sd16385, -16'sd1, 1'b1);
    chk("sat_before", sat_flag, 0);
    feed_e(38'sd2147483648, 16'sd32767, 1'b1);
    chk("sat_set", sat_flag, 1);
    feed_e(-38'sd2147483648, -16'sd32768, 1'b1);
    repeat (FRAME-6) feed(38'sd0);
    finish_frame(FRAME, 1);
    chk("sat_sticky", sat_flag, 1);
    chk("round_ovf", overflow, 0);

    // Backpressure: 20 captured into a 16-deep FIFO
    bus.out_ready = 1'b0;
    arm_frame();
    repeat (N-1) feed(38'sd0);
    for (int j = 0; j < 20; j++) feed_e(sc(100+j), 16'(100+j), j < DEPTH);
    tick(); tick();
    for (int j = 0; j < 3; j++) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", bus.out_data, 100);
      tick();
    end
    chk("ovf_set", overflow, 1);
    bus.out_ready = 1'b1;
    repeat (20) tick();
    chk("drain16_n", n_out, DEPTH);
    chk("drain16_sb", sbq.size(), 0);
    for (int j = 0; j < FRAME-20; j++) feed(sc(200+j));
    finish_frame(FRAME-4, 1);
    chk("ovf_sticky", overflow, 1);

    // Write into a full FIFO coinciding with a pop
    bus.out_ready = 1'b0;
    arm_frame();
    repeat (N-1) feed(38'sd0);
    for (int j = 0; j < DEPTH+1; j++) feed(sc(300+j));
    bus.out_ready = 1'b1;
    for (int j = DEPTH+1; j < FRAME; j++) feed(sc(-j));
    finish_frame(FRAME, 1);
    chk("full_pop_ovf", overflow, 0);

    // Reset mid-frame, then a clean frame
    bus.out_ready = 1'b1;
    arm_frame();
    repeat (N-1) feed(38'sd0);
    feed(38'sd2147483648);
    for (int j = 1; j < 500; j++) feed(sc(j));
    chk("pre_rst_sat", sat_flag, 1);
    chk("pre_rst_valid", bus.out_valid, 1);
    rst = 1'b0;
    #2;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_last", bus.out_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_sat", sat_flag, 0);
    chk("mid_rst_ovf", overflow, 0);
    sbq.delete();
    tick();
    rst = 1'b1;
    tick();
    run_ramp();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
